// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - guess-the-number round FSM feeding the seven-segment display controller
module round_sequencer #(
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter logic [15:0] RESULT_HOLD = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] guess,
  input  logic       disp_done,
  output logic [7:0] disp_value,
  output logic       disp_trigger,
  output logic       correct,
  output logic       wrong,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW,
    S_WAIT_DISP,
    S_WAIT_GUESS,
    S_RESULT
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]  LFSR_MASK = 8'hB8;
  localparam logic [15:0] HOLD_LOAD = RESULT_HOLD - 16'd1;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  disp_value_q, disp_value_d;
  logic        disp_trigger_q, disp_trigger_d;
  logic        correct_q, correct_d;
  logic        wrong_q, wrong_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  best_q, best_d;
  logic        busy_q, busy_d;
  logic [15:0] hold_q, hold_d;
  logic        start_prev_q, start_prev_d;
  logic        submit_prev_q, submit_prev_d;
  logic        done_prev_q, done_prev_d;

  logic        start_rise;
  logic        submit_rise;
  logic        done_rise;
  logic [7:0]  score_inc;

  assign start_rise  = start & ~start_prev_q;
  assign submit_rise = submit & ~submit_prev_q;
  assign done_rise   = disp_done & ~done_prev_q;

  // Next-state, LFSR step, score bookkeeping and registered outputs.
  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    target_d       = target_q;
    disp_value_d   = disp_value_q;
    disp_trigger_d = 1'b0;
    correct_d      = correct_q;
    wrong_d        = wrong_q;
    score_d        = score_q;
    best_d         = best_q;
    hold_d         = hold_q;
    start_prev_d   = start;
    submit_prev_d  = submit;
    done_prev_d    = disp_done;
    score_inc      = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (start_rise) state_d = S_GEN;
      end
      S_GEN: begin
        target_d       = lfsr_q;
        disp_value_d   = lfsr_q;
        disp_trigger_d = 1'b1;
        state_d        = S_SHOW;
      end
      S_SHOW: begin
        state_d = S_WAIT_DISP;
      end
      S_WAIT_DISP: begin
        // A submit edge here is deliberately dropped, even if it coincides with done.
        if (done_rise) state_d = S_WAIT_GUESS;
      end
      S_WAIT_GUESS: begin
        if (submit_rise) begin
          hold_d  = HOLD_LOAD;
          state_d = S_RESULT;
          if (guess == target_q) begin
            correct_d = 1'b1;
            score_d   = score_inc;
            best_d    = (score_inc > best_q) ? score_inc : best_q;
          end else begin
            wrong_d = 1'b1;
            score_d = 8'd0;
            best_d  = (score_q > best_q) ? score_q : best_q;
          end
        end
      end
      S_RESULT: begin
        if (hold_q == 16'd0) begin
          correct_d = 1'b0;
          wrong_d   = 1'b0;
          state_d   = correct_q ? S_GEN : S_IDLE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous active-low reset; edge detectors reset high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED_EFF;
      target_q       <= 8'd0;
      disp_value_q   <= 8'd0;
      disp_trigger_q <= 1'b0;
      correct_q      <= 1'b0;
      wrong_q        <= 1'b0;
      score_q        <= 8'd0;
      best_q         <= 8'd0;
      busy_q         <= 1'b0;
      hold_q         <= 16'd0;
      start_prev_q   <= 1'b1;
      submit_prev_q  <= 1'b1;
      done_prev_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      target_q       <= target_d;
      disp_value_q   <= disp_value_d;
      disp_trigger_q <= disp_trigger_d;
      correct_q      <= correct_d;
      wrong_q        <= wrong_d;
      score_q        <= score_d;
      best_q         <= best_d;
      busy_q         <= busy_d;
      hold_q         <= hold_d;
      start_prev_q   <= start_prev_d;
      submit_prev_q  <= submit_prev_d;
      done_prev_q    <= done_prev_d;
    end
  end

  assign disp_value   = disp_value_q;
  assign disp_trigger = disp_trigger_q;
  assign correct      = correct_q;
  assign wrong        = wrong_q;
  assign score        = score_q;
  assign best         = best_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - randomized self-checking bench for round_sequencer
module tb_round_sequencer;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int         HOLD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [7:0] guess = 8'd0;
  logic       disp_done = 1'b0;
  logic [7:0] disp_value;
  logic       disp_trigger;
  logic       correct;
  logic       wrong;
  logic [7:0] score;
  logic [7:0] best;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt = 0;
  int m_score = 0;
  int m_best = 0;
  int cnt0;
  logic [7:0] first_target;
  logic [7:0] cur_target;

  round_sequencer #(.SEED(SEED), .RESULT_HOLD(16'(HOLD))) dut (
    .clk(clk), .rst(rst), .start(start), .submit(submit), .guess(guess),
    .disp_done(disp_done), .disp_value(disp_value), .disp_trigger(disp_trigger),
    .correct(correct), .wrong(wrong), .score(score), .best(best), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge: the LFSR has stepped exactly this many times.
  always @(posedge clk) begin
    if (!rst) cnt <= 0;
    else cnt <= cnt + 1;
  end

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for the trigger, let the display finish, answer, and check the result phase.
  task automatic do_round(input bit right, input bit pre_submit);
    int n;
    n = 0;
    while (!disp_trigger && n < 20) begin
      tick();
      n++;
    end
    if (!disp_trigger) check("trigger_timeout", 0, 1);
    cur_target = lfsr_at(cnt - 1);
    check("disp_value", disp_value, cur_target);
    tick();
    check("trigger_one_cycle", disp_trigger, 0);
    if (pre_submit) begin
      submit = 1'b1;
      tick();
      submit = 1'b0;
      tick();
      check("early_submit_ignored", {busy, correct, wrong}, 3'b100);
    end
    repeat ($urandom_range(0, 3)) tick();
    disp_done = 1'b1;
    tick();
    disp_done = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    guess = right ? cur_target : (cur_target ^ 8'($urandom_range(1, 255)));
    submit = 1'b1;
    tick();
    submit = 1'b0;
    if (right) begin
      m_score = (m_score == 255) ? 255 : m_score + 1;
      if (m_score > m_best) m_best = m_score;
    end else begin
      if (m_score > m_best) m_best = m_score;
      m_score = 0;
    end
    check("result_flags", {correct, wrong}, right ? 2'b10 : 2'b01);
    check("score", score, m_score);
    check("best", best, m_best);
    n = 0;
    while ((correct || wrong) && n < 100) begin
      n++;
      tick();
    end
    check("hold_cycles", n, HOLD);
    check("busy_after", busy, right);
    check("disp_value_held", disp_value, cur_target);
  endtask

  initial begin
    // Buttons held through and after reset give no edge.
    rst = 1'b0; start = 1'b1; submit = 1'b1;
    tick(); tick();
    check("reset_outputs", {disp_value, disp_trigger, correct, wrong, score, best, busy}, 0);
    rst = 1'b1;
    repeat (4) begin
      tick();
      check("held_start_no_game", {busy, disp_trigger}, 0);
    end
    start = 1'b0; submit = 1'b0;
    repeat ($urandom_range(2, 8)) tick();

    // Start latency and first target.
    cnt0 = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("gen_no_trigger", {busy, disp_trigger}, 2'b10);
    tick();
    check("show_trigger", disp_trigger, 1);
    first_target = lfsr_at(cnt - 1);
    check("first_target", disp_value, first_target);

    do_round(1'b1, 1'b1);
    do_round(1'b1, 1'b0);
    do_round(1'b1, 1'b0);
    do_round(1'b0, 1'b0);
    check("best_three", best, 3);

    // Random games, each ending on a wrong answer.
    for (int g = 0; g < 6; g++) begin
      repeat ($urandom_range(1, 5)) tick();
      start_game();
      for (int r = 0; r < 5; r++) begin
        if (r == 4 || $urandom_range(0, 2) == 0) begin
          do_round(1'b0, $urandom_range(0, 1) == 1);
          break;
        end
        do_round(1'b1, $urandom_range(0, 1) == 1);
      end
    end

    // Saturation over 260 consecutive correct answers.
    tick();
    start_game();
    for (int r = 0; r < 260; r++) do_round(1'b1, 1'b0);
    check("score_sat", score, 255);
    do_round(1'b0, 1'b0);
    check("best_sat", best, 255);

    // Reset while waiting for a guess, then replay the first game's timing.
    start_game();
    while (!disp_trigger && cnt < 100000) tick();
    tick();
    disp_done = 1'b1;
    tick();
    disp_done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset_clear", {score, best, disp_value, busy, correct, wrong, disp_trigger}, 0);
    while (cnt < cnt0) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("replay_trigger", disp_trigger, 1);
    check("replay_target", disp_value, first_target);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
